// File: rtl/accel_nonce_sched.sv
// Nonce-sweep scheduler: issues one hash per nonce to the SHA-256d core and reports the first digest at or below target.
// Optional hash_done watchdog enabled by defining ACCEL_NONCE_SCHED_WDOG_EN.
module accel_nonce_sched #(
  parameter int unsigned WDOG_CYCLES = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         job_valid,
  output logic         job_ready,
  input  logic [639:0] job_hdr,
  input  logic [31:0]  job_nonce_start,
  input  logic [31:0]  job_nonce_end,
  input  logic [255:0] job_target,
  input  logic         abort,
  output logic         hash_start,
  output logic [639:0] blk_hdr,
  input  logic         hash_done,
  input  logic [255:0] hash,
  output logic         busy,
  output logic [31:0]  nonce_cur,
  output logic         res_valid,
  input  logic         res_ready,
  output logic         res_found,
  output logic         res_aborted,
  output logic         res_err,
  output logic [31:0]  res_nonce,
  output logic [255:0] res_hash
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CHECK, REPORT} state_t;

  state_t         state, state_nxt;
  logic [607:0]   hdr_q;
  logic [31:0]    end_q;
  logic [255:0]   target_q;
  logic           abort_pend;
  logic [255:0]   hash_le;
  logic           found_hit;
  logic           last_nonce;
  logic           stop_req;
  logic           timeout;
  logic           unused_inputs;

  function automatic logic [31:0] bswap32(input logic [31:0] x);
    bswap32 = {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic logic [255:0] bswap256(input logic [255:0] x);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) r[8*i +: 8] = x[8*(31-i) +: 8];
    bswap256 = r;
  endfunction

  // The digest arrives big-endian; the target compare works on its little-endian value.
  assign hash_le    = bswap256(res_hash);
  assign found_hit  = (hash_le <= target_q);
  assign last_nonce = (nonce_cur == end_q);
  assign stop_req   = abort_pend || abort;

  assign job_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign hash_start = (state == ISSUE);
  assign res_valid  = (state == REPORT);
  assign res_nonce  = nonce_cur;

  assign unused_inputs = ^{job_hdr[31:0], (WDOG_CYCLES != 0)};

`ifdef ACCEL_NONCE_SCHED_WDOG_EN
  localparam logic [31:0] WDOG_LAST = 32'(WDOG_CYCLES - 1);

  logic [31:0] wdog_cnt;
  logic        res_err_q;

  assign timeout = (wdog_cnt == WDOG_LAST);
  assign res_err = res_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_cnt  <= '0;
      res_err_q <= 1'b0;
    end else begin
      if (state == ISSUE) wdog_cnt <= '0;
      else if (state == WAIT) wdog_cnt <= wdog_cnt + 32'd1;
      if (state == IDLE && job_valid) res_err_q <= 1'b0;
      else if (state == WAIT && !hash_done && timeout) res_err_q <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign res_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (job_valid) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (hash_done) state_nxt = CHECK;
               else if (timeout) state_nxt = REPORT;
      CHECK:   if (found_hit || last_nonce || stop_req) state_nxt = REPORT;
               else state_nxt = ISSUE;
      REPORT:  if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // blk_hdr is only rewritten on the way into ISSUE, so it stays stable for the whole hash.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr_q       <= '0;
      end_q       <= '0;
      target_q    <= '0;
      nonce_cur   <= '0;
      abort_pend  <= 1'b0;
      blk_hdr     <= '0;
      res_hash    <= '0;
      res_found   <= 1'b0;
      res_aborted <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (job_valid) begin
            hdr_q      <= job_hdr[639:32];
            end_q      <= job_nonce_end;
            target_q   <= job_target;
            nonce_cur  <= job_nonce_start;
            abort_pend <= 1'b0;
            blk_hdr    <= {job_hdr[639:32], bswap32(job_nonce_start)};
          end
        end
        ISSUE: begin
          if (abort) abort_pend <= 1'b1;
        end
        WAIT: begin
          if (abort) abort_pend <= 1'b1;
          if (hash_done) begin
            res_hash <= hash;
          end else if (timeout) begin
            res_hash    <= '0;
            res_found   <= 1'b0;
            res_aborted <= 1'b0;
          end
        end
        CHECK: begin
          if (abort) abort_pend <= 1'b1;
          if (found_hit) begin
            res_found   <= 1'b1;
            res_aborted <= 1'b0;
          end else if (last_nonce) begin
            res_found   <= 1'b0;
            res_aborted <= 1'b0;
          end else if (stop_req) begin
            res_found   <= 1'b0;
            res_aborted <= 1'b1;
          end else begin
            nonce_cur <= nonce_cur + 32'd1;
            blk_hdr   <= {hdr_q, bswap32(nonce_cur + 32'd1)};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_accel_nonce_sched.sv
// Directed self-checking bench for accel_nonce_sched with a latency-programmable hash core stub.
// Watchdog scenario follows ACCEL_NONCE_SCHED_WDOG_EN when it is defined for the build.
module tb_accel_nonce_sched;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         job_valid = 1'b0;
  logic         job_ready;
  logic [639:0] job_hdr = '0;
  logic [31:0]  job_nonce_start = '0;
  logic [31:0]  job_nonce_end = '0;
  logic [255:0] job_target = '0;
  logic         abort = 1'b0;
  logic         hash_start;
  logic [639:0] blk_hdr;
  logic         hash_done;
  logic [255:0] hash;
  logic         busy;
  logic [31:0]  nonce_cur;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic         res_found, res_aborted, res_err;
  logic [31:0]  res_nonce;
  logic [255:0] res_hash;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  int           stub_mode = 0;
  int           stub_lat = 4;
  int           stub_cnt;
  logic [31:0]  stub_nonce;
  logic [639:0] hdr_tpl;

  int           hs_cyc[$];
  logic [639:0] hs_hdr[$];

  accel_nonce_sched #(.WDOG_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .job_valid(job_valid), .job_ready(job_ready), .job_hdr(job_hdr),
    .job_nonce_start(job_nonce_start), .job_nonce_end(job_nonce_end), .job_target(job_target),
    .abort(abort), .hash_start(hash_start), .blk_hdr(blk_hdr),
    .hash_done(hash_done), .hash(hash), .busy(busy), .nonce_cur(nonce_cur),
    .res_valid(res_valid), .res_ready(res_ready), .res_found(res_found),
    .res_aborted(res_aborted), .res_err(res_err), .res_nonce(res_nonce), .res_hash(res_hash)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] bswap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic logic [255:0] bswap256(input logic [255:0] x);
    logic [255:0] r;
    for (int i = 0; i < 32; i++) r[8*i +: 8] = x[8*(31-i) +: 8];
    return r;
  endfunction

  // Hash core stub: mode 0 gives hash_le = 20 - nonce, mode 1 gives nonce + 1, mode 2 never answers.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stub_cnt   <= 0;
      stub_nonce <= '0;
      hash_done  <= 1'b0;
      hash       <= '0;
    end else begin
      hash_done <= 1'b0;
      if (hash_start && stub_mode != 2) begin
        stub_cnt   <= stub_lat - 1;
        stub_nonce <= bswap32(blk_hdr[31:0]);
      end else if (stub_cnt != 0) begin
        stub_cnt <= stub_cnt - 1;
        if (stub_cnt == 1) begin
          hash_done <= 1'b1;
          hash <= bswap256(stub_mode == 0 ? 256'(32'd20 - stub_nonce) : 256'(stub_nonce) + 256'd1);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && hash_start) begin
      hs_cyc.push_back(cyc);
      hs_hdr.push_back(blk_hdr);
    end
  end

  task automatic send_job(input logic [31:0] s, input logic [31:0] e, input logic [255:0] t,
                          output int acc);
    job_hdr = hdr_tpl;
    job_nonce_start = s;
    job_nonce_end = e;
    job_target = t;
    job_valid = 1'b1;
    acc = -1;
    for (int i = 0; i < 20 && acc < 0; i++) begin
      if (job_ready) acc = cyc;
      @(negedge clk);
    end
    job_valid = 1'b0;
    n_cmp++;
    if (acc < 0) begin
      n_fail++;
      $display("[TB] FAIL job_accept: job_ready never seen, required 1");
    end
  endtask

  task automatic wait_result(input int budget, output int at_cyc);
    bit seen;
    seen = 1'b0;
    at_cyc = -1;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (res_valid) begin
        seen = 1'b1;
        at_cyc = cyc;
      end
    end
    n_cmp++;
    if (!seen) begin
      n_fail++;
      $display("[TB] FAIL result_timeout: res_valid=0 after %0d cycles, required 1", budget);
    end
  endtask

  task automatic release_result();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if ({job_ready, busy, hash_start, res_valid, res_found, res_aborted, res_err} !== 7'b1000000) begin
      n_fail++;
      $display("[TB] FAIL reset_flags: got %b, required 1000000",
               {job_ready, busy, hash_start, res_valid, res_found, res_aborted, res_err});
    end
    n_cmp++;
    if (blk_hdr !== '0 || nonce_cur !== '0 || res_nonce !== '0 || res_hash !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_data: nonce_cur=%h res_nonce=%h, required all data zero", nonce_cur, res_nonce);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_find_equal();
    int acc, r;
    logic [31:0]  exp_n[4];
    logic [255:0] exp_hash;
    exp_n = '{32'h05000000, 32'h06000000, 32'h07000000, 32'h08000000};
    exp_hash = {8'h0C, 248'd0};
    hs_cyc.delete(); hs_hdr.delete();
    stub_mode = 0; stub_lat = 4;
    send_job(32'd5, 32'd10, 256'd12, acc);
    wait_result(200, r);
    n_cmp++;
    if (hs_cyc.size() !== 4) begin
      n_fail++;
      $display("[TB] FAIL find_issue_count: got %0d, required 4", hs_cyc.size());
    end
    for (int i = 0; i < 4 && i < hs_cyc.size(); i++) begin
      n_cmp++;
      if (hs_hdr[i][31:0] !== exp_n[i] || hs_hdr[i][639:32] !== hdr_tpl[639:32]) begin
        n_fail++;
        $display("[TB] FAIL find_blk_hdr%0d: nonce slot %h, required %h", i, hs_hdr[i][31:0], exp_n[i]);
      end
    end
    for (int i = 1; i < hs_cyc.size(); i++) begin
      n_cmp++;
      if (hs_cyc[i] - hs_cyc[i-1] !== 6) begin
        n_fail++;
        $display("[TB] FAIL find_spacing%0d: got %0d, required 6", i, hs_cyc[i] - hs_cyc[i-1]);
      end
    end
    n_cmp++;
    if (hs_cyc.size() == 0 || hs_cyc[0] !== acc + 1) begin
      n_fail++;
      $display("[TB] FAIL find_start_latency: accept at %0d, first hash_start missing or late, required %0d", acc, acc + 1);
    end
    n_cmp++;
    if ({res_found, res_aborted, res_err} !== 3'b100 || res_nonce !== 32'd8) begin
      n_fail++;
      $display("[TB] FAIL find_result: status %b nonce %0d, required 100 nonce 8",
               {res_found, res_aborted, res_err}, res_nonce);
    end
    n_cmp++;
    if (res_hash !== exp_hash) begin
      n_fail++;
      $display("[TB] FAIL find_hash: got %h, required %h", res_hash, exp_hash);
    end
    release_result();
  endtask

  task automatic test_wrap_exhaust();
    int acc, r;
    logic [31:0]  exp_n[4];
    logic [255:0] exp_hash;
    exp_n = '{32'hFEFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h01000000};
    exp_hash = {8'h02, 248'd0};
    hs_cyc.delete(); hs_hdr.delete();
    stub_mode = 1; stub_lat = 3;
    send_job(32'hFFFFFFFE, 32'h00000001, 256'd0, acc);
    wait_result(200, r);
    n_cmp++;
    if (hs_cyc.size() !== 4) begin
      n_fail++;
      $display("[TB] FAIL wrap_issue_count: got %0d, required 4", hs_cyc.size());
    end
    for (int i = 0; i < 4 && i < hs_cyc.size(); i++) begin
      n_cmp++;
      if (hs_hdr[i][31:0] !== exp_n[i]) begin
        n_fail++;
        $display("[TB] FAIL wrap_nonce%0d: got %h, required %h", i, hs_hdr[i][31:0], exp_n[i]);
      end
    end
    n_cmp++;
    if ({res_found, res_aborted, res_err} !== 3'b000 || res_nonce !== 32'd1 || res_hash !== exp_hash) begin
      n_fail++;
      $display("[TB] FAIL wrap_result: status %b nonce %h, required 000 nonce 00000001",
               {res_found, res_aborted, res_err}, res_nonce);
    end
    release_result();
  endtask

  task automatic test_abort();
    int acc, r, s;
    hs_cyc.delete(); hs_hdr.delete();
    stub_mode = 1; stub_lat = 130;
    send_job(32'd0, 32'd100, 256'd0, acc);
    n_cmp++;
    if (hash_start !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL abort_first_start: hash_start=%b, required 1", hash_start);
    end
    s = cyc;
    repeat (10) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_result(300, r);
    n_cmp++;
    if (r !== s + 132) begin
      n_fail++;
      $display("[TB] FAIL abort_result_time: res_valid at %0d, required %0d", r, s + 132);
    end
    n_cmp++;
    if (hs_cyc.size() !== 1) begin
      n_fail++;
      $display("[TB] FAIL abort_issue_count: got %0d, required 1", hs_cyc.size());
    end
    n_cmp++;
    if ({res_found, res_aborted, res_err} !== 3'b010 || res_nonce !== 32'd0) begin
      n_fail++;
      $display("[TB] FAIL abort_result: status %b nonce %0d, required 010 nonce 0",
               {res_found, res_aborted, res_err}, res_nonce);
    end
    release_result();
  endtask

  task automatic test_back_to_back();
    int acc, r, hs_before;
    hs_cyc.delete(); hs_hdr.delete();
    stub_mode = 0; stub_lat = 4;
    send_job(32'd8, 32'd8, 256'd12, acc);
    wait_result(100, r);
    job_nonce_start = 32'd9;
    job_nonce_end = 32'd9;
    job_target = 256'd12;
    job_valid = 1'b1;
    hs_before = hs_cyc.size();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (res_valid !== 1'b1 || res_found !== 1'b1 || res_nonce !== 32'd8 || job_ready !== 1'b0 ||
          hash_start !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL stall_cycle%0d: valid=%b found=%b nonce=%0d ready=%b start=%b, required 1 1 8 0 0",
                 i, res_valid, res_found, res_nonce, job_ready, hash_start);
      end
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    n_cmp++;
    if (job_ready !== 1'b1 || hs_cyc.size() !== hs_before) begin
      n_fail++;
      $display("[TB] FAIL stall_release: job_ready=%b, required 1 with no extra hash_start", job_ready);
    end
    @(negedge clk);
    job_valid = 1'b0;
    n_cmp++;
    if (hash_start !== 1'b1 || blk_hdr[31:0] !== 32'h09000000) begin
      n_fail++;
      $display("[TB] FAIL next_job_start: hash_start=%b nonce slot %h, required 1 09000000",
               hash_start, blk_hdr[31:0]);
    end
    wait_result(100, r);
    n_cmp++;
    if (res_found !== 1'b1 || res_nonce !== 32'd9) begin
      n_fail++;
      $display("[TB] FAIL next_job_result: found=%b nonce=%0d, required 1 9", res_found, res_nonce);
    end
    release_result();
  endtask

  task automatic test_watchdog();
    int acc;
`ifdef ACCEL_NONCE_SCHED_WDOG_EN
    int r, s;
    stub_mode = 2;
    send_job(32'd0, 32'd5, 256'd0, acc);
    s = cyc;
    wait_result(100, r);
    n_cmp++;
    if (r !== s + 17) begin
      n_fail++;
      $display("[TB] FAIL wdog_time: res_valid at %0d, required %0d", r, s + 17);
    end
    n_cmp++;
    if ({res_found, res_aborted, res_err} !== 3'b001 || res_hash !== '0) begin
      n_fail++;
      $display("[TB] FAIL wdog_result: status %b, required 001 with zero hash",
               {res_found, res_aborted, res_err});
    end
    release_result();
`else
    bit held;
    stub_mode = 2;
    send_job(32'd0, 32'd5, 256'd0, acc);
    held = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (busy !== 1'b1 || res_valid !== 1'b0) held = 1'b0;
    end
    n_cmp++;
    if (held !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL nowdog_hold: busy dropped or result appeared, required busy for 1000 cycles");
    end
    n_cmp++;
    if (res_err !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL nowdog_err: got %b, required 0", res_err);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
`endif
  endtask

  task automatic test_async_reset();
    int acc;
    stub_mode = 2;
    send_job(32'h33, 32'h40, 256'd0, acc);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1 || nonce_cur !== 32'h33) begin
      n_fail++;
      $display("[TB] FAIL areset_pre: busy=%b nonce_cur=%h, required 1 00000033", busy, nonce_cur);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({job_ready, busy, hash_start, res_valid, res_found, res_aborted, res_err} !== 7'b1000000 ||
        blk_hdr !== '0 || nonce_cur !== '0 || res_nonce !== '0 || res_hash !== '0) begin
      n_fail++;
      $display("[TB] FAIL areset_outputs: flags %b nonce_cur=%h, required 1000000 and zero data",
               {job_ready, busy, hash_start, res_valid, res_found, res_aborted, res_err}, nonce_cur);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (job_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL areset_release: job_ready=%b busy=%b, required 1 0", job_ready, busy);
    end
  endtask

  initial begin
    hdr_tpl = {{19{32'hA5C30F1E}}, 32'hDEADBEEF};
    test_reset();
    test_find_equal();
    test_wrap_exhaust();
    test_abort();
    test_back_to_back();
    test_watchdog();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: bench still running, required completion");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/accel_nonce_sched.md
# accel_nonce_sched

Nonce-sweep scheduler for the SHA-256d block-header accelerator. Accepts one mining job: an 80-byte header template, an inclusive nonce range, and a 256-bit target. It sequences the accelerator through one `hash_start`/`hash_done` transaction per nonce and compares each digest against the target. It returns a single result record through a valid/ready handshake, and sits between the host job/result interface and the `accel` hash core.

## Interface
Parameters:
- `WDOG_CYCLES`, default 255: maximum cycles waited for `hash_done`. Used only under `ACCEL_NONCE_SCHED_WDOG_EN`.

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `job_valid`  in  1  job offered
- `job_ready`  out  1  high only in IDLE
- `job_hdr`  in  640  header template; bits [31:0] ignored (nonce slot)
- `job_nonce_start`  in  32  first nonce
- `job_nonce_end`  in  32  last nonce, inclusive
- `job_target`  in  256  target, unsigned
- `abort`  in  1  stop the sweep after the in-flight hash
- `hash_start`  out  1  one-cycle pulse to the accelerator
- `blk_hdr`  out  640  header to the accelerator, registered
- `hash_done`  in  1  accelerator digest valid this cycle
- `hash`  in  256  accelerator digest, big-endian byte order
- `busy`  out  1  not IDLE
- `nonce_cur`  out  32  nonce currently issued
- `res_valid`  out  1  result record valid
- `res_ready`  in  1  result consumed
- `res_found`, `res_aborted`, `res_err`  out  1 each  result status
- `res_nonce`  out  32  last nonce hashed
- `res_hash`  out  256  digest of `res_nonce`

## Operation
The block is a state machine with five states: IDLE, ISSUE, WAIT, CHECK, REPORT.
- **IDLE**
  - `job_ready`=1.
  - On `job_valid`: latch header, end and target; set `nonce_cur`=start; clear `abort_pend`; go to ISSUE.
- **ISSUE**
  - `hash_start`=1 for exactly one cycle.
  - `blk_hdr` = {`job_hdr`[639:32], byteswap(`nonce_cur`)}, i.e. [31:24]=nonce[7:0] … [7:0]=nonce[31:24].
  - `blk_hdr` is updated on ISSUE entry and held stable through WAIT.
  - Next state: WAIT.
- **WAIT**
  - On `hash_done`: capture `hash` into `res_hash`; go to CHECK.
- **CHECK**, priority order:
  1. `hash_le` ≤ target → REPORT with found=1. `hash_le` is the byte-reverse of the captured hash, compared as a 256-bit unsigned value.
  2. `nonce_cur`==end → REPORT with found=0 (range exhausted).
  3. `abort_pend` → REPORT with aborted=1.
  4. Otherwise `nonce_cur`+1 mod 2^32 → ISSUE. Ranges with end<start wrap through 0xFFFFFFFF→0.
- **REPORT**
  - `res_valid`=1.
  - `res_*` fields stay stable until `res_valid`&`res_ready`, then go to IDLE.
  - `res_nonce`=`nonce_cur`.
- **`abort`**
  - Sets `abort_pend` in ISSUE, WAIT or CHECK.
  - Ignored in IDLE and REPORT.
  - The in-flight hash is always completed; the accelerator is never cut off mid-hash.
  - A nonce that matches in the same CHECK reports found=1, aborted=0.
- **Ignored inputs**
  - `hash_done` outside WAIT.
  - `job_valid` outside IDLE.

## Timing
- **Reset values** (asserted asynchronously): state=IDLE, `job_ready`=1. All other outputs are 0, including `blk_hdr`, `nonce_cur` and all `res_*`.
- **Reset mid-job:** the job is dropped. The bench must reset the accelerator as well.
- **Job start:** job accepted at cycle T → `hash_start` high at T+1.
- **Per-nonce period:** `hash_start` at S and `hash_done` at S+L → CHECK at S+L+1 → next `hash_start` at S+L+2. Period = L+2.
- **Result timing:** `res_valid` rises the cycle after CHECK. `job_ready` rises the cycle after the result handshake.
- **Arithmetic:** 32-bit wrapping increment. The 256-bit compare is unsigned; equality counts as found.

## Configuration
- **`ACCEL_NONCE_SCHED_WDOG_EN` defined:**
  - A counter is cleared on WAIT entry and increments each WAIT cycle.
  - On reaching `WDOG_CYCLES` without `hash_done`: go to REPORT with err=1, found=0, aborted=0, and `res_hash`=0.
  - A `hash_done` in the same cycle as the timeout wins.
- **Undefined:** no counter; `res_err` is tied to 0; WAIT waits indefinitely.

## Test plan
1. **Find with equality:** stub L=4 returning `hash_le`=20−nonce; start=5, end=10, target=12 → `hash_start` pulses for nonces 5–8 only; found=1, `res_nonce`=8, `hash_le`(`res_hash`)=12. Checks along the way:
   - `blk_hdr`[31:0]=0x08000000 for nonce 8.
   - `hash_start` spacing is 6 cycles.
2. **Wrap and exhaust:** stub returns `hash_le`=nonce+1 (256-bit); start=0xFFFFFFFE, end=0x00000001, target=0 → nonces FFFFFFFE, FFFFFFFF, 0, 1 issued; found=0, aborted=0, `res_nonce`=1.
3. **Abort:** L=130, start=0, end=100; `abort` pulsed 10 cycles after the first `hash_start` → no second `hash_start`; aborted=1, `res_nonce`=0, `res_valid` at cycle L+2 after `hash_start`.
4. **Backpressure:** hold `res_ready`=0 for 5 cycles with `job_valid` asserted → `res_*` stable, `job_ready`=0, no new `hash_start`; after the handshake, `job_ready`=1 and the next job is accepted.
5. **Watchdog** (macro defined, `WDOG_CYCLES`=16): stub never asserts `hash_done` → err=1 exactly 16 WAIT cycles after entry. With the macro undefined, `busy` stays 1 for 1000 cycles.
6. **Async reset:** `rst_n`=0 mid-WAIT → outputs reach reset values before the next clock edge; `job_ready`=1 once `rst_n` is released.
